// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - host/core side signal bundle for the CPU run controller
// Host commands and core feedback in, core drive and held run status out.
interface cpu_run_ctrl_if #(
    parameter int CW = 16
);
    logic          start;
    logic          abort;
    logic          core_done;
    logic          core_reset;
    logic          core_req;
    logic          busy;
    logic          finished;
    logic          timeout;
    logic [CW-1:0] cycles;

    modport master (
        output start,
        output abort,
        output core_done,
        input  core_reset,
        input  core_req,
        input  busy,
        input  finished,
        input  timeout,
        input  cycles
    );

    modport slave (
        input  start,
        input  abort,
        input  core_done,
        output core_reset,
        output core_req,
        output busy,
        output finished,
        output timeout,
        output cycles
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - start/reset/req sequencer with cycle counter and watchdog
// Turns a host start into core reset + req, then counts RUN cycles until done or timeout.
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    cpu_run_ctrl_if.slave         io_bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_TMO   = 3'd5;

    localparam int            RCW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]  LIMIT_M1 = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0]  LIMIT    = CW'(MAX_CYCLES);

    logic [2:0]     r_state;
    logic [RCW-1:0] r_rst_cnt;
    logic [CW-1:0]  r_cycles;
    logic           r_finished;
    logic           r_timeout;
    logic           w_launch;

    // Abort only competes with start while idle; in DONE/TMO start always wins.
    assign w_launch = io_bus.start &&
                      ((r_state == S_DONE) || (r_state == S_TMO) ||
                       ((r_state == S_IDLE) && !io_bus.abort));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rst_cnt  <= '0;
            r_cycles   <= '0;
            r_finished <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (w_launch) begin
            r_state    <= S_RESET;
            r_rst_cnt  <= RST_LOAD;
            r_cycles   <= '0;
            r_finished <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (io_bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (r_rst_cnt == '0) begin
                        r_state <= S_REQ;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - 1'b1;
                    end
                end
                S_REQ: begin
                    r_state <= io_bus.abort ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    if (io_bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (io_bus.core_done) begin
                        r_state    <= S_DONE;
                        r_finished <= 1'b1;
                    end else if (r_cycles == LIMIT_M1) begin
                        r_state   <= S_TMO;
                        r_cycles  <= LIMIT;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cycles <= r_cycles + 1'b1;
                    end
                end
                S_IDLE, S_DONE, S_TMO: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The core is only held in reset before a run, never after one, so its memory stays readable.
    assign io_bus.core_reset = (r_state == S_IDLE) || (r_state == S_RESET);
    assign io_bus.core_req   = (r_state == S_REQ);
    assign io_bus.busy       = (r_state == S_RESET) || (r_state == S_REQ) || (r_state == S_RUN);
    assign io_bus.finished   = r_finished;
    assign io_bus.timeout    = r_timeout;
    assign io_bus.cycles     = r_cycles;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed vector bench for cpu_run_ctrl
// Per-cycle table of inputs and expected outputs, plus async-reset and latency sequences.
module tb_cpu_run_ctrl;
    localparam int RST_CYCLES = 2;
    localparam int CW         = 16;
    localparam int MAX_CYCLES = 8;

    typedef struct {
        logic        st;
        logic        ab;
        logic        cd;
        logic [20:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    cpu_run_ctrl_if #(.CW(CW)) bus ();

    cpu_run_ctrl #(
        .RST_CYCLES(RST_CYCLES),
        .CW        (CW),
        .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] o(input logic r, input logic q, input logic b,
                                      input logic f, input logic t, input int c);
        return {r, q, b, f, t, c[15:0]};
    endfunction

    function automatic logic [20:0] outs();
        return {bus.core_reset, bus.core_req, bus.busy, bus.finished, bus.timeout, bus.cycles};
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rst/req/busy/fin/tmo/cyc=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
                     name, act[20], act[19], act[18], act[17], act[16], act[15:0],
                     exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    task automatic add(input logic st, input logic ab, input logic cd, input logic [20:0] exp);
        vec_t v;
        v.st = st; v.ab = ab; v.cd = cd; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic ab, input logic cd);
        bus.start = st; bus.abort = ab; bus.core_done = cd;
    endtask

    initial begin
        logic [20:0] idle_o, rs_o, rq_o;
        int lat;
        idle_o = o(1, 0, 0, 0, 0, 0);
        rs_o   = o(1, 0, 1, 0, 0, 0);
        rq_o   = o(0, 1, 1, 0, 0, 0);

        // normal run: done in 6th RUN cycle, with ignored core_done in REQ and start in RUN
        add(1, 0, 0, rs_o);
        add(0, 0, 0, rs_o);
        add(0, 0, 0, rq_o);
        add(0, 0, 1, o(0, 0, 1, 0, 0, 0));
        add(0, 0, 0, o(0, 0, 1, 0, 0, 1));
        add(1, 0, 0, o(0, 0, 1, 0, 0, 2));
        add(0, 0, 0, o(0, 0, 1, 0, 0, 3));
        add(0, 0, 0, o(0, 0, 1, 0, 0, 4));
        add(0, 0, 0, o(0, 0, 1, 0, 0, 5));
        add(0, 0, 1, o(0, 0, 0, 1, 0, 5));
        add(0, 0, 1, o(0, 0, 0, 1, 0, 5));
        add(0, 1, 0, o(0, 0, 0, 1, 0, 5));
        // restart from DONE then watchdog
        add(1, 0, 0, rs_o);
        add(0, 0, 0, rs_o);
        add(0, 0, 0, rq_o);
        add(0, 0, 0, o(0, 0, 1, 0, 0, 0));
        for (int n = 1; n < MAX_CYCLES; n++) add(0, 0, 0, o(0, 0, 1, 0, 0, n));
        add(0, 0, 0, o(0, 0, 0, 0, 1, MAX_CYCLES));
        add(0, 0, 1, o(0, 0, 0, 0, 1, MAX_CYCLES));
        add(0, 1, 0, o(0, 0, 0, 0, 1, MAX_CYCLES));
        // restart from TMO, abort in RESET, start+abort in IDLE, abort in REQ
        add(1, 0, 0, rs_o);
        add(0, 0, 0, rs_o);
        add(0, 1, 0, idle_o);
        add(1, 1, 0, idle_o);
        add(1, 0, 0, rs_o);
        add(0, 0, 0, rs_o);
        add(0, 0, 0, rq_o);
        add(0, 1, 0, idle_o);
        // abort together with core_done in RUN: cycles held, not finished
        add(1, 0, 0, rs_o);
        add(0, 0, 0, rs_o);
        add(0, 0, 0, rq_o);
        add(0, 0, 0, o(0, 0, 1, 0, 0, 0));
        add(0, 0, 0, o(0, 0, 1, 0, 0, 1));
        add(0, 1, 1, o(1, 0, 0, 0, 0, 1));

        drive(0, 0, 0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", outs(), idle_o);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("reset_release", outs(), idle_o);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].ab, vecs[i].cd);
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // async reset in RUN cycle 3, between edges
        drive(1, 0, 0);
        @(posedge clk);
        #1 drive(0, 0, 0);
        repeat (5) @(posedge clk);
        #1 check("run3_before_reset", outs(), o(0, 0, 1, 0, 0, 2));
        #2 rst = 1'b1;
        #1 check("async_reset", outs(), idle_o);
        drive(1, 0, 0);
        @(posedge clk);
        #1 check("reset_ignores_start", outs(), idle_o);
        drive(0, 0, 0);
        @(negedge clk) rst = 1'b0;

        // full sequence again after reset: latency to req, one-cycle req, then done
        @(posedge clk);
        #1 drive(1, 0, 0);
        @(posedge clk);
        #1 drive(0, 0, 0);
        lat = 1;
        while (!bus.core_req && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        check("req_latency", 21'(lat), 21'(RST_CYCLES + 1));
        check("req_outputs", outs(), rq_o);
        @(posedge clk);
        #1 check("req_one_cycle", outs(), o(0, 0, 1, 0, 0, 0));
        @(posedge clk);
        #1 drive(0, 0, 1);
        lat = 0;
        do begin
            @(posedge clk);
            #1 drive(0, 0, 0);
            lat++;
        end while (!bus.finished && lat < 20);
        check("done_after_reset", outs(), o(0, 0, 0, 1, 0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that sits directly upstream of the CPU `top_level`. It converts a single host `start` pulse into a clean core reset sequence followed by a one-cycle `req` strobe. It then watches the core's `done` output, counts execution cycles, and enforces a watchdog limit. Final status (finished / timeout / cycle count) is held for the host or testbench until the next start.

## Interface
- `RST_CYCLES`, default 2: number of cycles `core_reset` is held high after a start (≥1).
- `CW`, default 16: width of the cycle counter.
- `MAX_CYCLES`, default 1000: watchdog limit in RUN cycles (1 ≤ MAX_CYCLES < 2^CW).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  host request to run a program; sampled per cycle.
- `abort`  in  1  host cancel; sampled per cycle.
- `core_done`  in  1  from `top_level.done`; sampled synchronously.
- `core_reset`  out  1  drives `top_level.reset`.
- `core_req`  out  1  drives `top_level.req`.
- `busy`  out  1  high in RESET, REQ, RUN.
- `finished`  out  1  sticky; program reached halt.
- `timeout`  out  1  sticky; watchdog expired.
- `cycles`  out  CW  RUN cycles counted before halt or timeout.

## Operation
- States: IDLE, RESET, REQ, RUN, DONE, TMO. All outputs are registered or decoded from state (Moore); there are no combinational input-to-output paths.
- `core_reset` = 1 in IDLE and RESET, 0 in all other states. The core stays frozen while idle. The core is not reset after DONE or TMO, so its data memory stays readable.
- `core_req` = 1 only in REQ.
- IDLE: `start`=1 and `abort`=0 → RESET; clear `cycles`, `finished`, `timeout`; load the reset counter with RST_CYCLES-1.
- RESET: decrement the reset counter. At 0 → REQ.
- REQ: lasts exactly one cycle → RUN. `core_done` is ignored here.
- RUN, evaluated in priority order:
  - `abort` → IDLE.
  - Else `core_done` → DONE; `finished` ← 1; `cycles` is not incremented.
  - Else if `cycles` == MAX_CYCLES-1: `cycles` ← MAX_CYCLES; `timeout` ← 1; → TMO.
  - Else `cycles` ← `cycles`+1.
- DONE / TMO: hold all status. `core_done` is ignored. `start` → RESET, with the same clearing as from IDLE.
- `abort` in RESET or REQ → IDLE. `abort` in IDLE, DONE or TMO has no effect.
- `start` while `busy` is ignored.
- On `abort`, `cycles` holds its last value, and `finished` and `timeout` stay 0.
- Arithmetic: `cycles` is unsigned CW bits and cannot exceed MAX_CYCLES, so it never wraps.

## Timing
- Reset values, applied immediately (asynchronously) on `reset`:
  - state = IDLE
  - `core_reset`=1, `core_req`=0, `busy`=0, `finished`=0, `timeout`=0, `cycles`=0.
- `start` sampled high at edge k:
  - `core_reset` stays 1 for cycles k+1 … k+RST_CYCLES.
  - `core_req`=1 and `core_reset`=0 in cycle k+RST_CYCLES+1.
  - RUN begins at cycle k+RST_CYCLES+2.
- `busy` rises one cycle after `start` is sampled and falls in the same cycle `finished` or `timeout` rises.
- `core_done` high in the n-th RUN cycle (n=1 for the first) gives `cycles`=n-1, with `finished`=1 in the following cycle.
- With `core_done` never high, `timeout`=1 and `cycles`=MAX_CYCLES appear one cycle after the MAX_CYCLES-th RUN cycle.
- `reset` asserted in any state, including mid-RUN, returns to the reset values without waiting for a clock edge. Normal operation resumes from the first edge after deassertion.

## Test plan
- Reset → outputs: async `reset` pulse between clock edges → `core_reset`=1, `core_req`=0, `busy`=0, `finished`=0, `timeout`=0, `cycles`=0 immediately, before the next edge.
- Normal run: RST_CYCLES=2; `start` one cycle; `core_done`=1 in the 6th RUN cycle → `core_reset` high for 2 cycles, `core_req` exactly 1 cycle, then `finished`=1, `cycles`=5, `busy`=0, `core_reset` stays 0.
- Watchdog: MAX_CYCLES=8; `core_done` held 0 → `timeout`=1, `cycles`=8, `finished`=0. A new `start` clears `timeout` and re-runs the sequence.
- Ignored inputs: `start` pulsed during RUN → no restart, `cycles` keeps counting. `core_done`=1 during REQ → no effect, state still RUN next cycle.
- Simultaneous events:
  - `abort` and `core_done` both high in RUN → IDLE, `finished`=0, `core_reset`=1.
  - `start` and `abort` both high in IDLE → stays IDLE.
- Reset mid-run: assert `reset` at RUN cycle 3 → all outputs return to reset values at once. After deassertion, a `start` produces the full RESET/REQ/RUN sequence again.
